// File: rtl/msum_seq_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : msum_seq_pkg
//  Description : Shared types and constants for the multi-operand sequential
//                summer: operand width and the controller state encoding.
//  Revision    : 1.0 - initial release
// ============================================================================
package msum_seq_pkg;

    localparam int OP_W = 8;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        GATHER = 3'd1,
        ISSUE  = 3'd2,
        WAIT   = 3'd3,
        DONE   = 3'd4
    } state_t;

endpackage : msum_seq_pkg
`default_nettype wire

// File: rtl/msum_seq.sv
`default_nettype none
// ============================================================================
//  Module      : msum_seq
//  Description : Sums a burst of up to 2^CNT_W-1 byte operands by gathering
//                them in pairs and issuing each pair, together with the low
//                byte of the running total, to an external 3-input adder.
//                The adder carry is folded into the upper accumulator bits.
//  Revision    : 1.0 - initial release
// ============================================================================
module msum_seq
    import msum_seq_pkg::*;
#(
    parameter int CNT_W = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [CNT_W-1:0]      count,
    input  logic                  op_valid,
    input  logic [OP_W-1:0]       op_data,
    output logic                  op_ready,
    output logic [OP_W-1:0]       add_a,
    output logic [OP_W-1:0]       add_b,
    output logic [OP_W-1:0]       add_c,
    output logic                  add_en,
    input  logic [OP_W-1:0]       add_sum,
    input  logic [1:0]            add_cy,
    output logic                  busy,
    output logic                  done,
    output logic [OP_W+CNT_W-1:0] result
);

    localparam int ACC_W = OP_W + CNT_W;

    state_t             r_state;
    state_t             w_state_next;
    logic [CNT_W-1:0]   r_rem;
    logic [1:0]         r_held;
    logic [OP_W-1:0]    r_op0;
    logic [OP_W-1:0]    r_op1;
    logic [ACC_W-1:0]   r_acc;

    logic               w_xfer;
    logic [1:0]         w_held_inc;
    logic [CNT_W+1:0]   w_held_x;
    logic [CNT_W+1:0]   w_inc_x;
    logic [CNT_W+1:0]   w_rem_x;
    logic [CNT_W-1:0]   w_rem_left;

    // Held-count arithmetic widened so it compares cleanly against remaining
    assign w_xfer     = op_valid & op_ready;
    assign w_held_inc = r_held + 2'd1;
    assign w_held_x   = {{CNT_W{1'b0}}, r_held};
    assign w_inc_x    = {{CNT_W{1'b0}}, w_held_inc};
    assign w_rem_x    = {2'b00, r_rem};
    assign w_rem_left = r_rem - CNT_W'(r_held);

    // The total is presented straight from the accumulator; it only changes
    // during a burst, so it holds between done and the next start.
    assign result = r_acc;

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state and Moore/handshake outputs
    always_comb begin
        w_state_next = r_state;
        op_ready     = 1'b0;
        add_en       = 1'b0;
        add_a        = '0;
        add_b        = '0;
        add_c        = '0;
        busy         = 1'b1;
        done         = 1'b0;
        case (r_state)
            IDLE: begin
                busy = 1'b0;
                if (start) begin
                    w_state_next = (count != '0) ? GATHER : DONE;
                end
            end
            GATHER: begin
                op_ready = (r_held < 2'd2) && (w_held_x < w_rem_x);
                // Leave as soon as the accepting transfer fills the pair or
                // exhausts the burst, so ISSUE follows the last transfer.
                if (w_xfer && ((w_held_inc == 2'd2) || (w_inc_x == w_rem_x))) begin
                    w_state_next = ISSUE;
                end
            end
            ISSUE: begin
                add_en       = 1'b1;
                add_a        = r_acc[OP_W-1:0];
                add_b        = r_op0;
                add_c        = (r_held == 2'd2) ? r_op1 : '0;
                w_state_next = WAIT;
            end
            WAIT: begin
                w_state_next = (w_rem_left == '0) ? DONE : GATHER;
            end
            DONE: begin
                done         = 1'b1;
                w_state_next = IDLE;
            end
            default: begin
                w_state_next = IDLE;
            end
        endcase
    end

    // Operand slots, remaining count and accumulator
    always_ff @(posedge clk) begin
        if (rst) begin
            r_rem  <= '0;
            r_held <= '0;
            r_op0  <= '0;
            r_op1  <= '0;
            r_acc  <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (start) begin
                        r_rem  <= count;
                        r_held <= '0;
                        r_acc  <= '0;
                    end
                end
                GATHER: begin
                    if (w_xfer) begin
                        if (r_held == 2'd0) begin
                            r_op0 <= op_data;
                        end else begin
                            r_op1 <= op_data;
                        end
                        r_held <= w_held_inc;
                    end
                end
                WAIT: begin
                    r_acc[OP_W-1:0]     <= add_sum;
                    r_acc[ACC_W-1:OP_W] <= r_acc[ACC_W-1:OP_W] + CNT_W'(add_cy);
                    r_rem               <= w_rem_left;
                    r_held              <= '0;
                end
                default: begin
                end
            endcase
        end
    end

endmodule : msum_seq
`default_nettype wire

// File: tb/tb_msum_seq.sv
`default_nettype none
// ============================================================================
//  Module      : tb_msum_seq
//  Description : Directed self-checking bench for msum_seq with a registered
//                3-input adder model and a negedge activity monitor.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_msum_seq;

    localparam int CNT_W = 4;

    logic             clk = 1'b0;
    logic             rst;
    logic             start;
    logic [CNT_W-1:0] count;
    logic             op_valid;
    logic [7:0]       op_data;
    logic             op_ready;
    logic [7:0]       add_a;
    logic [7:0]       add_b;
    logic [7:0]       add_c;
    logic             add_en;
    logic [7:0]       add_sum;
    logic [1:0]       add_cy;
    logic             busy;
    logic             done;
    logic [11:0]      result;

    int checks   = 0;
    int failures = 0;

    // monitor state
    int          cyc      = 0;
    int          n_pass   = 0;
    int          n_done   = 0;
    int          n_viol   = 0;
    int          n_zviol  = 0;
    int          mon_held = 0;
    int          done_cyc = 0;
    logic [11:0] done_res = '0;
    logic [23:0] pass_log [0:63];

    logic [7:0]  ops [0:15];
    int          s_cyc;

    msum_seq #(.CNT_W(CNT_W)) dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .count    (count),
        .op_valid (op_valid),
        .op_data  (op_data),
        .op_ready (op_ready),
        .add_a    (add_a),
        .add_b    (add_b),
        .add_c    (add_c),
        .add_en   (add_en),
        .add_sum  (add_sum),
        .add_cy   (add_cy),
        .busy     (busy),
        .done     (done),
        .result   (result)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // External adder: result valid the cycle after add_en
    always @(posedge clk) begin
        if (add_en) begin
            {add_cy, add_sum} <= 10'(add_a) + 10'(add_b) + 10'(add_c);
        end else begin
            {add_cy, add_sum} <= '0;
        end
    end

    // Activity monitor sampled mid-cycle
    always @(negedge clk) begin
        if (add_en) begin
            pass_log[n_pass % 64] <= {add_a, add_b, add_c};
            n_pass <= n_pass + 1;
        end
        if (done) begin
            n_done   <= n_done + 1;
            done_cyc <= cyc;
            done_res <= result;
        end
        if (op_ready && mon_held >= 2) n_viol <= n_viol + 1;
        if (!add_en && ((add_a | add_b | add_c) != 8'd0)) n_zviol <= n_zviol + 1;
        if (rst || add_en) mon_held <= 0;
        else if (op_valid && op_ready) mon_held <= mon_held + 1;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Start a burst, feed ops[0..cnt-1], optionally stop feeding after
    // rst_after transfers; optionally pulse start during the final WAIT.
    task automatic run_burst(input string tag, input int cnt, input bit gaps,
                             input int rst_after, input bit pulse_wait);
        int  i      = 0;
        int  guard  = 0;
        int  base   = n_done;
        bit  pulsed = 1'b0;
        @(posedge clk); #1;
        start = 1'b1;
        count = CNT_W'(cnt);
        @(negedge clk);
        s_cyc = cyc;
        @(posedge clk); #1;
        start = 1'b0;
        while (i < cnt && guard < 400) begin
            if (rst_after >= 0 && i == rst_after) break;
            op_valid = gaps ? ($urandom_range(0, 2) != 0) : 1'b1;
            op_data  = op_valid ? ops[i] : 8'h00;
            @(negedge clk);
            if (op_valid && op_ready) i++;
            @(posedge clk); #1;
            guard++;
        end
        op_valid = 1'b0;
        op_data  = 8'h00;
        if (rst_after >= 0) return;
        check({tag, "_ops_taken"}, i, cnt);
        for (int k = 0; k < 200 && n_done == base; k++) begin
            @(negedge clk);
            if (pulse_wait && add_en && !pulsed) begin
                pulsed = 1'b1;
                @(posedge clk); #1;
                start = 1'b1;
                count = 4'd3;
                @(posedge clk); #1;
                start = 1'b0;
            end
        end
        check({tag, "_done_seen"}, n_done - base, 1);
    endtask

    initial begin
        int p0;
        int d0;
        rst      = 1'b1;
        start    = 1'b0;
        count    = '0;
        op_valid = 1'b0;
        op_data  = '0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_busy",     busy, 0);
        check("rst_done",     done, 0);
        check("rst_op_ready", op_ready, 0);
        check("rst_add_en",   add_en, 0);
        check("rst_add_abc",  {add_a, add_b, add_c}, 0);
        check("rst_result",   result, 0);
        rst = 1'b0;

        // count=5, operands 1..5, no stalls
        for (int k = 0; k < 5; k++) ops[k] = 8'(k + 1);
        p0 = n_pass;
        run_burst("s1", 5, 1'b0, -1, 1'b0);
        check("s1_passes", n_pass - p0, 3);
        check("s1_pass0",  pass_log[(p0 + 0) % 64], 24'h000102);
        check("s1_pass1",  pass_log[(p0 + 1) % 64], 24'h030304);
        check("s1_pass2",  pass_log[(p0 + 2) % 64], 24'h0A0500);
        check("s1_result", done_res, 12'd15);
        check("s1_latency", done_cyc - s_cyc, 12);
        repeat (3) @(posedge clk);
        #1;
        check("s1_result_held", result, 12'd15);
        check("s1_idle_after", busy, 0);

        // count=3, all 255: carry into upper accumulator
        for (int k = 0; k < 3; k++) ops[k] = 8'hFF;
        p0 = n_pass;
        run_burst("s2", 3, 1'b0, -1, 1'b0);
        check("s2_passes", n_pass - p0, 2);
        check("s2_pass1",  pass_log[(p0 + 1) % 64], 24'hFEFF00);
        check("s2_result", done_res, 12'h2FD);
        check("s2_latency", done_cyc - s_cyc, 8);

        // count=15, all 255, random op_valid gaps
        for (int k = 0; k < 15; k++) ops[k] = 8'hFF;
        p0 = n_pass;
        run_burst("s3", 15, 1'b1, -1, 1'b0);
        check("s3_passes", n_pass - p0, 8);
        check("s3_result", done_res, 12'hEF1);
        check("s3_ready_at_held2", n_viol, 0);

        // count=0: straight to DONE
        p0 = n_pass;
        run_burst("s4", 0, 1'b0, -1, 1'b0);
        check("s4_passes", n_pass - p0, 0);
        check("s4_result", done_res, 12'd0);
        check("s4_latency", done_cyc - s_cyc, 1);

        // count=4 with start pulsed during the final WAIT
        ops[0] = 8'd10; ops[1] = 8'd20; ops[2] = 8'd30; ops[3] = 8'd40;
        d0 = n_done;
        run_burst("s5", 4, 1'b0, -1, 1'b1);
        check("s5_result", done_res, 12'd100);
        repeat (12) @(posedge clk);
        #1;
        check("s5_single_done", n_done - d0, 1);
        check("s5_idle_after",  busy, 0);

        // reset mid-GATHER after 3 of 6 operands, then a fresh burst
        for (int k = 0; k < 6; k++) ops[k] = 8'(k + 1);
        d0 = n_done;
        run_burst("s6", 6, 1'b0, 3, 1'b0);
        rst = 1'b1;
        @(posedge clk); #1;
        check("s6_busy_after_rst",  busy, 0);
        check("s6_ready_after_rst", op_ready, 0);
        check("s6_result_cleared",  result, 0);
        rst = 1'b0;
        repeat (6) @(posedge clk);
        #1;
        check("s6_no_done", n_done - d0, 0);
        ops[0] = 8'd7; ops[1] = 8'd8;
        run_burst("s6b", 2, 1'b0, -1, 1'b0);
        check("s6b_result",  done_res, 12'd15);
        check("s6b_latency", done_cyc - s_cyc, 5);

        check("adder_ops_zero_when_idle", n_zviol, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule : tb_msum_seq
`default_nettype wire
